// File: rtl/mchan_ipa_pkg.sv
// rtl/mchan_ipa_pkg.sv - shared MCHAN widths, mode/state encodings and captured command type
//
// Purpose : common definitions for the MCHAN n-D transfer splitter.
// Contents: opcode/length widths, transfer mode enum, splitter state enum,
//           packed struct for the command fields that travel with every chunk,
//           and the raw-mode decoder (11 falls back to 1D).
package mchan_ipa_pkg;

  localparam int MCHAN_OPC_WIDTH = 4;
  localparam int MCHAN_LEN_WIDTH = 16;

  typedef enum logic [1:0] {
    MODE_1D = 2'b00,
    MODE_2D = 2'b01,
    MODE_3D = 2'b10
  } mchan_mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } split_state_e;

  typedef struct packed {
    mchan_mode_e                mode;
    logic                       inc;
    logic [MCHAN_OPC_WIDTH-1:0] opc;
  } mchan_cmd_t;

  function automatic mchan_mode_e decode_mode(input logic [1:0] raw);
    case (raw)
      2'b01:   return MODE_2D;
      2'b10:   return MODE_3D;
      default: return MODE_1D;
    endcase
  endfunction

endpackage

// File: rtl/twd_chunk_len_calc.sv
// rtl/twd_chunk_len_calc.sv - chunk length = min(total left, row left, distance to burst boundary)
//
// Purpose : purely combinational chunk sizing for the n-D splitter.
// Ports   : tot_rem_i    - bytes left in the command (>= 1 while running)
//           row_rem_i    - bytes left in the current row
//           ext_off_i    - EXT address modulo the burst length
//           ignore_row_i - 1D transfer, row limit does not apply
//           chunk_o      - chunk size in bytes
//           last_o       - chunk finishes the command
module twd_chunk_len_calc
  import mchan_ipa_pkg::*;
#(
  parameter int TOT_W     = 17,
  parameter int ROW_W     = 17,
  parameter int OFF_W     = 6,
  parameter int BURST_LEN = 64,
  parameter int CHUNK_W   = 17
) (
  input  logic [TOT_W-1:0]   tot_rem_i,
  input  logic [ROW_W-1:0]   row_rem_i,
  input  logic [OFF_W-1:0]   ext_off_i,
  input  logic               ignore_row_i,
  output logic [CHUNK_W-1:0] chunk_o,
  output logic               last_o
);

  logic [CHUNK_W-1:0] tot_x;
  logic [CHUNK_W-1:0] row_x;
  logic [CHUNK_W-1:0] dist_x;
  logic [CHUNK_W-1:0] min_tr;

  assign tot_x  = CHUNK_W'(tot_rem_i);
  assign row_x  = CHUNK_W'(row_rem_i);
  // Always in 1..BURST_LEN, so one chunk never straddles an aligned burst.
  assign dist_x = CHUNK_W'(BURST_LEN) - CHUNK_W'(ext_off_i);

  always_comb begin
    min_tr = tot_x;
    if (!ignore_row_i && (row_x < min_tr)) begin
      min_tr = row_x;
    end
    chunk_o = (dist_x < min_tr) ? dist_x : min_tr;
  end

  assign last_o = (chunk_o == tot_x);

endmodule

// File: rtl/twd_trans_splitter_nd_ipa.sv
// rtl/twd_trans_splitter_nd_ipa.sv - splits one 1D/2D/3D MCHAN command into burst-safe 1D chunks
//
// Purpose : accepts a command in IDLE, then issues one chunk per accepted
//           handshake: packed TCDM addressing, row/plane strided EXT addressing,
//           no chunk crossing an EXT MCHAN_BURST_LENGTH boundary.
// Ports   : clk_i/rst_i                 - clock, async active-high reset
//           mchan_req_i/mchan_gnt_o     - command handshake (+ command fields)
//           mchan_req_o/mchan_gnt_i     - chunk handshake (+ chunk fields, last)
//           busy_o                      - command in flight
module twd_trans_splitter_nd_ipa
  import mchan_ipa_pkg::*;
#(
  parameter int TRANS_SID_WIDTH    = 1,
  parameter int TCDM_ADD_WIDTH     = 12,
  parameter int EXT_ADD_WIDTH      = 29,
  parameter int MCHAN_BURST_LENGTH = 64,
  parameter int TWD_COUNT_WIDTH    = 16,
  parameter int TWD_STRIDE_WIDTH   = 16
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        mchan_req_i,
  output logic                        mchan_gnt_o,
  input  logic [TRANS_SID_WIDTH-1:0]  mchan_sid_i,
  input  logic [MCHAN_OPC_WIDTH-1:0]  mchan_opc_i,
  input  logic                        mchan_inc_i,
  input  logic [1:0]                  mchan_mode_i,
  input  logic [MCHAN_LEN_WIDTH-1:0]  mchan_len_i,
  input  logic [TWD_COUNT_WIDTH-1:0]  mchan_row_len_i,
  input  logic [TWD_COUNT_WIDTH-1:0]  mchan_row_num_i,
  input  logic [TWD_STRIDE_WIDTH-1:0] mchan_row_stride_i,
  input  logic [TWD_STRIDE_WIDTH-1:0] mchan_plane_stride_i,
  input  logic [TCDM_ADD_WIDTH-1:0]   mchan_tcdm_add_i,
  input  logic [EXT_ADD_WIDTH-1:0]    mchan_ext_add_i,
  output logic                        mchan_req_o,
  input  logic                        mchan_gnt_i,
  output logic [TRANS_SID_WIDTH-1:0]  mchan_sid_o,
  output logic [MCHAN_OPC_WIDTH-1:0]  mchan_opc_o,
  output logic                        mchan_inc_o,
  output logic [MCHAN_LEN_WIDTH-1:0]  mchan_len_o,
  output logic [TCDM_ADD_WIDTH-1:0]   mchan_tcdm_add_o,
  output logic [EXT_ADD_WIDTH-1:0]    mchan_ext_add_o,
  output logic                        mchan_last_o,
  output logic                        busy_o
);

  // Remaining counters hold len+1 / row_len+1, hence one extra bit.
  localparam int TOT_W   = MCHAN_LEN_WIDTH + 1;
  localparam int ROW_W   = TWD_COUNT_WIDTH + 1;
  localparam int OFF_W   = $clog2(MCHAN_BURST_LENGTH);
  localparam int CW0     = (TOT_W > ROW_W) ? TOT_W : ROW_W;
  localparam int CHUNK_W = (CW0 > OFF_W + 1) ? CW0 : OFF_W + 1;

  split_state_e                state_q, state_d;
  mchan_cmd_t                  cmd_q, cmd_d;
  logic [TRANS_SID_WIDTH-1:0]  sid_q, sid_d;
  logic [TWD_COUNT_WIDTH-1:0]  row_len_q, row_len_d;
  logic [TWD_COUNT_WIDTH-1:0]  row_num_q, row_num_d;
  logic [TWD_STRIDE_WIDTH-1:0] row_stride_q, row_stride_d;
  logic [TWD_STRIDE_WIDTH-1:0] plane_stride_q, plane_stride_d;
  logic [TOT_W-1:0]            tot_rem_q, tot_rem_d;
  logic [ROW_W-1:0]            row_rem_q, row_rem_d;
  logic [TWD_COUNT_WIDTH-1:0]  row_idx_q, row_idx_d;
  logic [EXT_ADD_WIDTH-1:0]    row_base_q, row_base_d;
  logic [EXT_ADD_WIDTH-1:0]    plane_base_q, plane_base_d;
  logic [EXT_ADD_WIDTH-1:0]    ext_cur_q, ext_cur_d;
  logic [TCDM_ADD_WIDTH-1:0]   tcdm_cur_q, tcdm_cur_d;

  logic [CHUNK_W-1:0] chunk;
  logic               chunk_last;
  logic               is_1d;
  logic               row_done;
  logic               run;

  assign run   = (state_q == ST_RUN);
  assign is_1d = (cmd_q.mode == MODE_1D);

  twd_chunk_len_calc #(
    .TOT_W     (TOT_W),
    .ROW_W     (ROW_W),
    .OFF_W     (OFF_W),
    .BURST_LEN (MCHAN_BURST_LENGTH),
    .CHUNK_W   (CHUNK_W)
  ) u_chunk_len_calc (
    .tot_rem_i    (tot_rem_q),
    .row_rem_i    (row_rem_q),
    .ext_off_i    (ext_cur_q[OFF_W-1:0]),
    .ignore_row_i (is_1d),
    .chunk_o      (chunk),
    .last_o       (chunk_last)
  );

  assign row_done = !is_1d && (chunk == CHUNK_W'(row_rem_q));

  always_comb begin
    state_d        = state_q;
    cmd_d          = cmd_q;
    sid_d          = sid_q;
    row_len_d      = row_len_q;
    row_num_d      = row_num_q;
    row_stride_d   = row_stride_q;
    plane_stride_d = plane_stride_q;
    tot_rem_d      = tot_rem_q;
    row_rem_d      = row_rem_q;
    row_idx_d      = row_idx_q;
    row_base_d     = row_base_q;
    plane_base_d   = plane_base_q;
    ext_cur_d      = ext_cur_q;
    tcdm_cur_d     = tcdm_cur_q;

    case (state_q)
      ST_IDLE: begin
        if (mchan_req_i) begin
          cmd_d.mode     = decode_mode(mchan_mode_i);
          cmd_d.inc      = mchan_inc_i;
          cmd_d.opc      = mchan_opc_i;
          sid_d          = mchan_sid_i;
          row_len_d      = mchan_row_len_i;
          row_num_d      = mchan_row_num_i;
          row_stride_d   = mchan_row_stride_i;
          plane_stride_d = mchan_plane_stride_i;
          tot_rem_d      = TOT_W'(mchan_len_i) + TOT_W'(1);
          row_rem_d      = ROW_W'(mchan_row_len_i) + ROW_W'(1);
          row_idx_d      = '0;
          row_base_d     = mchan_ext_add_i;
          plane_base_d   = mchan_ext_add_i;
          ext_cur_d      = mchan_ext_add_i;
          tcdm_cur_d     = mchan_tcdm_add_i;
          state_d        = ST_RUN;
        end
      end
      ST_RUN: begin
        if (mchan_gnt_i) begin
          tcdm_cur_d = tcdm_cur_q + TCDM_ADD_WIDTH'(chunk);
          tot_rem_d  = tot_rem_q - TOT_W'(chunk);
          if (!row_done) begin
            ext_cur_d = ext_cur_q + EXT_ADD_WIDTH'(chunk);
            row_rem_d = row_rem_q - ROW_W'(chunk);
          end else begin
            row_rem_d = ROW_W'(row_len_q) + ROW_W'(1);
            if ((cmd_q.mode == MODE_3D) && (row_idx_q == row_num_q)) begin
              plane_base_d = plane_base_q + EXT_ADD_WIDTH'(plane_stride_q);
              row_base_d   = plane_base_d;
              ext_cur_d    = plane_base_d;
              row_idx_d    = '0;
            end else begin
              row_base_d = row_base_q + EXT_ADD_WIDTH'(row_stride_q);
              ext_cur_d  = row_base_d;
              row_idx_d  = row_idx_q + TWD_COUNT_WIDTH'(1);
            end
          end
          if (chunk_last) begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q        <= ST_IDLE;
      cmd_q          <= '0;
      sid_q          <= '0;
      row_len_q      <= '0;
      row_num_q      <= '0;
      row_stride_q   <= '0;
      plane_stride_q <= '0;
      tot_rem_q      <= '0;
      row_rem_q      <= '0;
      row_idx_q      <= '0;
      row_base_q     <= '0;
      plane_base_q   <= '0;
      ext_cur_q      <= '0;
      tcdm_cur_q     <= '0;
    end else begin
      state_q        <= state_d;
      cmd_q          <= cmd_d;
      sid_q          <= sid_d;
      row_len_q      <= row_len_d;
      row_num_q      <= row_num_d;
      row_stride_q   <= row_stride_d;
      plane_stride_q <= plane_stride_d;
      tot_rem_q      <= tot_rem_d;
      row_rem_q      <= row_rem_d;
      row_idx_q      <= row_idx_d;
      row_base_q     <= row_base_d;
      plane_base_q   <= plane_base_d;
      ext_cur_q      <= ext_cur_d;
      tcdm_cur_q     <= tcdm_cur_d;
    end
  end

  // Data outputs are forced to zero outside RUN so IDLE looks like reset.
  assign mchan_gnt_o      = !run;
  assign busy_o           = run;
  assign mchan_req_o      = run;
  assign mchan_last_o     = run & chunk_last;
  assign mchan_sid_o      = run ? sid_q : '0;
  assign mchan_opc_o      = run ? cmd_q.opc : '0;
  assign mchan_inc_o      = run & cmd_q.inc;
  assign mchan_len_o      = run ? MCHAN_LEN_WIDTH'(chunk - CHUNK_W'(1)) : '0;
  assign mchan_tcdm_add_o = run ? tcdm_cur_q : '0;
  assign mchan_ext_add_o  = run ? ext_cur_q : '0;

endmodule
